fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch controller upstream of the PC register. Produces next_pc
//  for the PC register and takes its current pc back. Issues in-order
//  instruction-memory requests at pc and buffers returned words with their PCs
//  in a FIFO for decode. Handles branch/jump redirects by flushing the FIFO and
//  discarding responses for wrong-path requests that are still in flight.
// PARAMETERS
//  DEPTH  4  instruction FIFO entries and max in-flight requests; power of 2, >=2
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  pc              in   32  current PC from PC register; address of next request
//  next_pc         out  32  PC register D input
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request
//  imem_req_addr   out  32  fetch address (== pc)
//  imem_rsp_valid  in   1   response valid; in order; no backpressure
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/jump taken: refetch from redirect_pc
//  redirect_pc     in   32  redirect target
//  inst_valid      out  1   FIFO head valid to decode
//  inst_ready      in   1   decode accepts head
//  inst_data       out  32  head instruction
//  inst_pc         out  32  head PC
// BEHAVIOUR
//  - State: FIFO (DEPTH x {pc,instr}), tag queue (DEPTH x pc), outstanding cnt
//    (0..DEPTH), drop_cnt (0..DEPTH). All counters/pointers 0 on reset.
//  - Reset: imem_req_valid=0, inst_valid=0; next_pc=pc (combinational).
//  - Issue: imem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH).
//    imem_req_addr = pc. Handshake pushes pc into tag queue, outstanding+1.
//  - next_pc priority: redirect_valid -> {redirect_pc[31:2],2'b00};
//    else handshake -> pc+4 (wraps mod 2^32); else pc.
//  - Response: pops tag queue, outstanding-1. If drop_cnt>0 or redirect_valid
//    that cycle -> discarded (drop_cnt-1 if >0); else {tag,data} pushed to FIFO.
//    Word visible on inst_* the cycle after rsp_valid (1-cycle buffer latency).
//  - Credit rule guarantees FIFO never overflows; response with outstanding==0
//    is ignored (protocol violation, no state change).
//  - Pop: inst_valid && inst_ready advances head. inst_valid = fifo_count!=0.
//  - Redirect (single cycle): FIFO flushed (count 0, pop that cycle ignored);
//    no request that cycle; drop_cnt <= outstanding + drop-adjusted: i.e.
//    drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0). Back-to-back redirects:
//    each recomputes drop_cnt from outstanding; last target wins.
//  - Simultaneous push+pop with FIFO full: allowed only via credits; push+pop
//    keeps count. Pointers wrap mod DEPTH.
//  - Reset mid-operation: all state cleared asynchronously; late imem responses
//    after reset are ignored by the outstanding==0 rule.
// TESTING
//  1 Reset, ready=1, 1-cycle imem echoing addr -> requests 0x0,0x4,0x8..;
//    inst_pc/inst_data pairs match, one per cycle with inst_ready=1.
//  2 inst_ready=0, DEPTH=4 -> exactly 4 requests issued, req_valid stays 0;
//    FIFO holds 0x0..0xC; release -> drains in order, fetch resumes at 0x10.
//  3 3-cycle imem latency, redirect to 0x103 with 2 in flight -> next_pc=0x100,
//    FIFO empty next cycle, 2 stale responses dropped, first inst_pc=0x100.
//  4 Redirect in same cycle as a response and a pop -> response dropped,
//    drop_cnt=outstanding-1, FIFO count 0, no request that cycle.
//  5 imem_req_ready=0 for 5 cycles -> req_valid held, addr and next_pc stable
//    at pc; no FIFO change; ready=1 -> single request, next_pc=pc+4.
//  6 pc=0xFFFFFFFC handshake -> next_pc=0x00000000; async rst mid-burst ->
//    inst_valid/req_valid 0 immediately, trailing rsp_valid ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: in-order instruction fetch with credit-limited requests, tagged response FIFO and redirect flush
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   pc / next_pc          current PC in, PC register D input out
//   imem_req_*            fetch request handshake, address == pc
//   imem_rsp_*            in-order responses, no backpressure
//   redirect_valid/_pc    taken branch/jump, target is word-aligned
//   inst_*                FIFO head {pc, instr} to decode, valid/ready
module fetch_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] fifo_pc_q [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];
    logic [31:0] tag_q [DEPTH];
    ptr_t wr_q, wr_d, rd_q, rd_d, twr_q, twr_d, trd_q, trd_d;
    cnt_t cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic [AW+1:0] used;
    logic hs, rsp_ok, push, pop;

    // Credits cover both buffered words and requests in flight, so the FIFO can never overflow
    always_comb begin
        used           = {1'b0, out_q} + {1'b0, cnt_q};
        imem_req_valid = !rst && !redirect_valid && (used < (AW+2)'(DEPTH));
        imem_req_addr  = pc;
        hs             = imem_req_valid && imem_req_ready;
        rsp_ok         = imem_rsp_valid && (out_q != '0);
        push           = rsp_ok && (drop_q == '0) && !redirect_valid;
        inst_valid     = cnt_q != '0;
        pop            = inst_valid && inst_ready && !redirect_valid;
        inst_pc        = fifo_pc_q[rd_q];
        inst_data      = fifo_data_q[rd_q];
        next_pc        = redirect_valid ? (redirect_pc & ~32'h3) : hs ? pc + 32'd4 : pc;
        out_d          = out_q + cnt_t'(hs) - cnt_t'(rsp_ok);
        // On redirect everything still in flight after this cycle belongs to the wrong path
        drop_d         = redirect_valid ? out_q - cnt_t'(rsp_ok) :
                         (rsp_ok && drop_q != '0) ? drop_q - cnt_t'(1) : drop_q;
        wr_d           = wr_q + ptr_t'(push);
        rd_d           = redirect_valid ? wr_q : rd_q + ptr_t'(pop);
        cnt_d          = redirect_valid ? '0 : cnt_q + cnt_t'(push) - cnt_t'(pop);
        twr_d          = twr_q + ptr_t'(hs);
        trd_d          = trd_q + ptr_t'(rsp_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            twr_q  <= '0;
            trd_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            twr_q  <= twr_d;
            trd_q  <= trd_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_q]   <= tag_q[trd_q];
            fifo_data_q[wr_q] <= imem_rsp_data;
        end
        if (hs) tag_q[twr_q] <= pc;
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard plus table-driven checks for fetch_ctrl
module tb_fetch_ctrl;
    localparam logic [31:0] K = 32'h5A5A_0000;

    logic clk = 0, rst = 0;
    logic [31:0] pc, pc_q, pc_set = 0, next_pc, req_addr, rsp_data = 0, rpc = 0, inst_data, inst_pc;
    logic pc_manual = 0, req_valid, req_ready = 0, rsp_valid = 0, rdv = 0, inst_valid, inst_ready = 0;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;
    typedef struct { logic [31:0] pc; logic rdv; logic [31:0] rpc; logic rdy; logic ev; logic [31:0] enp; } vec_t;

    req_t imq[$];
    ins_t exp_q[$];
    ins_t e;
    logic [31:0] hs_log[$], pop_log[$];
    int cyc = 0, lat = 1, n_vec = 0, n_err = 0, rst_evt = 0, rst_seen = 0;
    int h0, p0;
    vec_t tv[6];

    assign pc = pc_manual ? pc_set : pc_q;
    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) if (rst) pc_q <= 0; else pc_q <= next_pc;
    always @(posedge rst) rst_evt++;

    fetch_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(rdv), .redirect_pc(rpc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Instruction memory: in-order, fixed latency, echoes addr ^ K
    always @(posedge clk) begin
        cyc++;
        #1;
        if (imq.size() != 0 && imq[0].due <= cyc) begin
            rsp_valid = 1;
            rsp_data  = imq[0].addr ^ K;
        end else begin
            rsp_valid = 0;
            rsp_data  = 0;
        end
    end

    // Scoreboard: expected words pushed at request handshake, compared at decode pop
    always @(negedge clk) begin
        if (rsp_valid && imq.size() != 0) void'(imq.pop_front());
        if (rst || rst_evt != rst_seen) begin
            exp_q.delete();
            rst_seen = rst_evt;
        end
        if (!rst) begin
            if (inst_valid && inst_ready && !rdv) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_unexpected: got pc %h expected no word", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_data", inst_data, e.data);
                end
                pop_log.push_back(inst_pc);
            end
            if (rdv) exp_q.delete();
            if (req_valid) chk("req_addr", req_addr, pc);
            if (req_valid && req_ready) begin
                exp_q.push_back('{req_addr, req_addr ^ K});
                hs_log.push_back(req_addr);
                imq.push_back('{req_addr, cyc + lat});
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic quiesce_reset(int l);
        req_ready = 0;
        rdv = 0;
        pc_manual = 0;
        inst_ready = 1;
        for (int i = 0; i < 40 && imq.size() != 0; i++) tick();
        if (imq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", imq.size());
        end
        rst = 1;
        lat = l;
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_next_pc", next_pc, 0);
        tick(2);
        rst = 0;
        req_ready = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0104};
        tv[1] = '{32'h0000_0200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200};
        tv[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000};
        tv[3] = '{32'h0000_0040, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0000_0100};
        tv[4] = '{32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFC};
        tv[5] = '{32'h0000_0080, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_0004};

        // streaming fetch, 1-cycle memory
        quiesce_reset(1);
        h0 = hs_log.size();
        p0 = pop_log.size();
        tick(20);
        chk("t1_req0", hs_log[h0], 32'h0);
        chk("t1_req1", hs_log[h0+1], 32'h4);
        chk("t1_req2", hs_log[h0+2], 32'h8);
        chk("t1_rate", 32'(pop_log.size() - p0 >= 15), 1);
        chk("t1_inst_valid", inst_valid, 1);

        // decode stalled: credits cap requests at DEPTH
        quiesce_reset(1);
        inst_ready = 0;
        h0 = hs_log.size();
        tick(10);
        chk("t2_req_count", 32'(hs_log.size() - h0), 4);
        chk("t2_req3", hs_log[h0+3], 32'hC);
        chk("t2_req_valid", req_valid, 0);
        chk("t2_inst_valid", inst_valid, 1);
        chk("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1;
        tick(10);
        chk("t2_resume", hs_log[h0+4], 32'h10);

        // redirect with two requests in flight, 3-cycle memory
        quiesce_reset(3);
        h0 = hs_log.size();
        tick(2);
        rdv = 1;
        rpc = 32'h103;
        #1;
        chk("t3_inflight", 32'(hs_log.size() - h0), 2);
        chk("t3_next_pc", next_pc, 32'h100);
        chk("t3_req_valid", req_valid, 0);
        tick();
        rdv = 0;
        #1;
        chk("t3_flushed", inst_valid, 0);
        p0 = pop_log.size();
        tick(12);
        chk("t3_refetch", hs_log[h0+2], 32'h100);
        chk("t3_first_pc", pop_log[p0], 32'h100);

        // redirect coinciding with a response and a pop
        quiesce_reset(1);
        tick(6);
        rdv = 1;
        rpc = 32'h200;
        #1;
        chk("t4_inst_valid", inst_valid, 1);
        chk("t4_req_valid", req_valid, 0);
        tick();
        rdv = 0;
        #1;
        chk("t4_flushed", inst_valid, 0);
        chk("t4_req_valid_after", req_valid, 1);
        chk("t4_req_addr", req_addr, 32'h200);
        p0 = pop_log.size();
        tick(5);
        chk("t4_first_pc", pop_log[p0], 32'h200);

        // memory not ready: request held stable
        quiesce_reset(1);
        req_ready = 0;
        h0 = hs_log.size();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_req_valid", req_valid, 1);
            chk("t5_addr", req_addr, 32'h0);
            chk("t5_next_pc", next_pc, 32'h0);
            chk("t5_inst_valid", inst_valid, 0);
            tick();
        end
        req_ready = 1;
        #1;
        chk("t5_next_pc_hs", next_pc, 32'h4);
        tick();
        req_ready = 0;
        #1;
        chk("t5_single", 32'(hs_log.size() - h0), 1);
        chk("t5_next_pc_hold", next_pc, 32'h4);
        tick(4);

        // next_pc / request table, PC forced per vector
        quiesce_reset(1);
        tick(3);
        for (int i = 0; i < 6; i++) begin
            pc_manual = 1;
            pc_set = tv[i].pc;
            rdv = tv[i].rdv;
            rpc = tv[i].rpc;
            req_ready = tv[i].rdy;
            #1;
            chk($sformatf("tv%0d_req_valid", i), req_valid, tv[i].ev);
            chk($sformatf("tv%0d_next_pc", i), next_pc, tv[i].enp);
            chk($sformatf("tv%0d_addr", i), req_addr, tv[i].pc);
            tick();
        end
        pc_manual = 0;
        rdv = 0;
        req_ready = 1;
        tick(5);

        // asynchronous reset mid-burst, trailing responses ignored
        quiesce_reset(3);
        inst_ready = 0;
        tick(5);
        chk("t6_pre_valid", inst_valid, 1);
        @(negedge clk);
        #2;
        rst = 1;
        req_ready = 0;
        #1;
        chk("t6_rst_inst_valid", inst_valid, 0);
        chk("t6_rst_req_valid", req_valid, 0);
        #1;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_stale_ignored", inst_valid, 0);
        end
        inst_ready = 1;
        req_ready = 1;
        p0 = pop_log.size();
        tick(10);
        chk("t6_restart_pc", pop_log[p0], 32'h0);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
